uart_frame_tx: RTL and testbench



---
 rtl/uart_frame_tx.sv | 235 +++++++++++++++++++++++
 tb/tb_uart_frame_tx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_tx.sv
// 8N1 UART transmitter for packSend frames: header byte, FRAME_WORDS little-endian
// 16-bit words, then an additive checksum, paced byte-by-byte by a host clear-to-send.
module uart_frame_tx #(
  parameter int unsigned CLOCKFRQ    = 48_000_000,
  parameter int unsigned BAUDRATE    = 12_000_000,
  parameter int unsigned FRAME_WORDS = 8,
  parameter logic [7:0]  HDR_BYTE    = 8'hA6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frameReady,
  input  logic [15:0] dataVal,
  output logic        dataNext,
  output logic        dataFrameReset,
  input  logic        cts,
  output logic        tx,
  output logic        is_transmitting
);

  localparam int unsigned DIV    = CLOCKFRQ / BAUDRATE;
  localparam int unsigned BAUD_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
  localparam logic [7:0] LAST_IDX = 8'(FRAME_WORDS - 1);

  if (((CLOCKFRQ % BAUDRATE) != 32'd0) || (DIV < 32'd2)) begin : gBadDiv
    $error("uart_frame_tx: CLOCKFRQ/BAUDRATE must be an integer >= 2");
  end
  if ((FRAME_WORDS < 32'd1) || (FRAME_WORDS > 32'd255)) begin : gBadWords
    $error("uart_frame_tx: FRAME_WORDS must be in 1..255");
  end

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FRST = 3'd1,
    HDR  = 3'd2,
    LO   = 3'd3,
    HI   = 3'd4,
    CSUM = 3'd5
  } state_t;

  state_t            state_r;
  state_t            stateNext_s;
  logic              ctsMeta_r;
  logic              ctsSync_r;
  logic              cts_s;
  logic              hdrPend_r;
  logic              busy_r;
  logic              tx_r;
  logic [8:0]        shift_r;
  logic [BAUD_W-1:0] baudCnt_r;
  logic [3:0]        bitCnt_r;
  logic [7:0]        wordHi_r;
  logic [7:0]        wordIdx_r;
  logic [7:0]        csum_r;
  logic              frameReset_r;
  logic              transmitting_r;
  logic              lastCycle_s;
  logic              boundary_s;
  logic              load_s;
  logic [7:0]        loadByte_s;
  logic              wordLoad_s;
  logic              csumClr_s;
  logic              csumAdd_s;
  logic              idxInc_s;

  assign cts_s       = ctsSync_r;
  assign lastCycle_s = busy_r && (bitCnt_r == 4'd9) && (baudCnt_r == BAUD_LAST);
  // A stalled byte slot (serialiser idle, not the pending header) is also a boundary.
  assign boundary_s  = lastCycle_s || (!busy_r && !hdrPend_r);

  // Two-flop synchroniser for the asynchronous clear-to-send.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctsMeta_r <= 1'b0;
      ctsSync_r <= 1'b0;
    end else begin
      ctsMeta_r <= cts;
      ctsSync_r <= ctsMeta_r;
    end
  end

  // Frame state register plus the one-cycle header-load marker and registered strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= IDLE;
      hdrPend_r      <= 1'b0;
      frameReset_r   <= 1'b0;
      transmitting_r <= 1'b0;
    end else begin
      state_r        <= stateNext_s;
      hdrPend_r      <= (state_r == FRST);
      frameReset_r   <= (stateNext_s == FRST);
      transmitting_r <= (stateNext_s == HDR) || (stateNext_s == LO) ||
                        (stateNext_s == HI)  || (stateNext_s == CSUM);
    end
  end

  // Next-state and byte-load decode; every load after the header waits for cts_s.
  always_comb begin
    stateNext_s = state_r;
    load_s      = 1'b0;
    loadByte_s  = 8'h00;
    wordLoad_s  = 1'b0;
    csumClr_s   = 1'b0;
    csumAdd_s   = 1'b0;
    idxInc_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (frameReady && cts_s) begin
          stateNext_s = FRST;
        end else begin
          stateNext_s = IDLE;
        end
      end
      FRST: begin
        stateNext_s = HDR;
      end
      HDR: begin
        if (hdrPend_r) begin
          load_s     = 1'b1;
          loadByte_s = HDR_BYTE;
          csumClr_s  = 1'b1;
        end else if (boundary_s && cts_s) begin
          stateNext_s = LO;
          load_s      = 1'b1;
          loadByte_s  = dataVal[7:0];
          wordLoad_s  = 1'b1;
          csumAdd_s   = 1'b1;
        end else begin
          stateNext_s = HDR;
        end
      end
      LO: begin
        if (boundary_s && cts_s) begin
          stateNext_s = HI;
          load_s      = 1'b1;
          loadByte_s  = wordHi_r;
          csumAdd_s   = 1'b1;
        end else begin
          stateNext_s = LO;
        end
      end
      HI: begin
        if (boundary_s && cts_s) begin
          if (wordIdx_r < LAST_IDX) begin
            stateNext_s = LO;
            load_s      = 1'b1;
            loadByte_s  = dataVal[7:0];
            wordLoad_s  = 1'b1;
            csumAdd_s   = 1'b1;
            idxInc_s    = 1'b1;
          end else begin
            stateNext_s = CSUM;
            load_s      = 1'b1;
            loadByte_s  = csum_r;
          end
        end else begin
          stateNext_s = HI;
        end
      end
      CSUM: begin
        if (lastCycle_s) begin
          stateNext_s = IDLE;
        end else begin
          stateNext_s = CSUM;
        end
      end
      default: begin
        stateNext_s = IDLE;
      end
    endcase
  end

  // Byte serialiser: start bit, d[0]..d[7], stop bit, each DIV cycles; a load restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r    <= 1'b0;
      tx_r      <= 1'b1;
      shift_r   <= 9'h1FF;
      baudCnt_r <= BAUD_W'(0);
      bitCnt_r  <= 4'd0;
    end else if (load_s) begin
      busy_r    <= 1'b1;
      tx_r      <= 1'b0;
      shift_r   <= {1'b1, loadByte_s};
      baudCnt_r <= BAUD_W'(0);
      bitCnt_r  <= 4'd0;
    end else if (busy_r) begin
      if (baudCnt_r == BAUD_LAST) begin
        baudCnt_r <= BAUD_W'(0);
        if (bitCnt_r == 4'd9) begin
          busy_r <= 1'b0;
          tx_r   <= 1'b1;
        end else begin
          bitCnt_r <= bitCnt_r + 4'd1;
          tx_r     <= shift_r[0];
          shift_r  <= {1'b1, shift_r[8:1]};
        end
      end else begin
        baudCnt_r <= baudCnt_r + BAUD_W'(1);
      end
    end else begin
      tx_r <= 1'b1;
    end
  end

  // Word capture, word index and running checksum over data bytes only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wordHi_r  <= 8'h00;
      wordIdx_r <= 8'd0;
      csum_r    <= 8'h00;
    end else begin
      if (wordLoad_s) begin
        wordHi_r <= dataVal[15:8];
      end else begin
        wordHi_r <= wordHi_r;
      end
      if (csumClr_s) begin
        wordIdx_r <= 8'd0;
        csum_r    <= 8'h00;
      end else begin
        wordIdx_r <= idxInc_s ? (wordIdx_r + 8'd1) : wordIdx_r;
        csum_r    <= csumAdd_s ? (csum_r + loadByte_s) : csum_r;
      end
    end
  end

  // dataNext must coincide with the cycle dataVal is captured, so it is decoded, not registered.
  assign dataNext        = wordLoad_s;
  assign dataFrameReset  = frameReset_r;
  assign tx              = tx_r;
  assign is_transmitting = transmitting_r;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx (DIV=4, FRAME_WORDS=2): frame-level model checked
// every cycle, UART line decoder, and hand-computed literal expectations.
`timescale 1ns/1ps
module tb_uart_frame_tx;
  localparam int DIV       = 4;
  localparam int FW        = 2;
  localparam int NB        = 2*FW + 2;
  localparam int BYTE_CYC  = 10*DIV;
  localparam int FRAME_CYC = NB*BYTE_CYC;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic frameReady = 1'b0;
  logic cts = 1'b0;
  logic [15:0] dataVal = 16'h0000;
  logic dataNext, dataFrameReset, tx, is_transmitting;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [15:0] words [0:FW-1];
  int wordIdx = 0;
  logic [7:0] expBytes [0:NB-1];
  bit armed = 1'b0;
  int armT = 0;
  logic [7:0] rxQ [$];
  int rxStartQ [$];
  int dnQ [$];
  int dfrQ [$];

  uart_frame_tx #(
    .CLOCKFRQ(48_000_000), .BAUDRATE(12_000_000), .FRAME_WORDS(FW), .HDR_BYTE(8'hA6)
  ) dut (
    .clk(clk), .rst(rst), .frameReady(frameReady), .dataVal(dataVal),
    .dataNext(dataNext), .dataFrameReset(dataFrameReset), .cts(cts),
    .tx(tx), .is_transmitting(is_transmitting)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %b expected %b at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic chkN(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Model: header, each word low byte then high byte, then the byte sum mod 256.
  task automatic setFrame(input logic [15:0] w0, input logic [15:0] w1);
    logic [7:0] sum;
    sum = 8'h00;
    words[0] = w0;
    words[1] = w1;
    wordIdx = 0;
    expBytes[0] = 8'hA6;
    for (int i = 0; i < FW; i++) begin
      expBytes[1+2*i] = words[i][7:0];
      expBytes[2+2*i] = words[i][15:8];
      sum = sum + words[i][7:0] + words[i][15:8];
    end
    expBytes[NB-1] = sum;
    rxQ.delete();
    rxStartQ.delete();
    dnQ.delete();
    dfrQ.delete();
  endtask

  // Expected line level t cycles after the cycle the frame start was decided.
  function automatic logic expTx(input int t);
    int b;
    int p;
    if (t < 3 || t >= 3 + FRAME_CYC) return 1'b1;
    b = (t - 3) / BYTE_CYC;
    p = ((t - 3) % BYTE_CYC) / DIV;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return expBytes[b][p-1];
  endfunction

  function automatic logic expDn(input int t);
    for (int i = 0; i < FW; i++)
      if (t == 2 + (1 + 2*i)*BYTE_CYC) return 1'b1;
    return 1'b0;
  endfunction

  task automatic waitCyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkFrame(input string nm, input int frstCyc, input int dnGap, input int dur);
    chkN({nm, " byte count"}, rxQ.size(), NB);
    if (rxQ.size() == NB) begin
      for (int i = 0; i < NB; i++)
        chkN($sformatf("%s byte%0d", nm, i), 32'(rxQ[i]), 32'(expBytes[i]));
      chkN({nm, " header start"}, rxStartQ[0], frstCyc + 2);
      chkN({nm, " duration"}, rxStartQ[NB-1] + BYTE_CYC - rxStartQ[0], dur);
    end
    chkN({nm, " frameReset count"}, dfrQ.size(), 1);
    if (dfrQ.size() == 1) chkN({nm, " frameReset cycle"}, dfrQ[0], frstCyc);
    chkN({nm, " dataNext count"}, dnQ.size(), FW);
    if (dnQ.size() == FW) chkN({nm, " dataNext gap"}, dnQ[1] - dnQ[0], dnGap);
  endtask

  // Word source: advances to the next word the cycle after a consuming dataNext.
  initial forever begin
    @(posedge clk);
    #1;
    if (wordIdx < FW) dataVal = words[wordIdx];
  end

  // Monitor: event logging, UART decoder and the per-cycle model compare.
  initial begin
    int rxCnt;
    int k;
    int t;
    bit rxBusy;
    logic [7:0] rxSh;
    int rxStart;
    rxBusy = 1'b0; rxCnt = 0; rxSh = 8'h00; rxStart = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        rxBusy = 1'b0;
      end else begin
        if (dataNext === 1'b1) begin dnQ.push_back(cyc); wordIdx = wordIdx + 1; end
        if (dataFrameReset === 1'b1) dfrQ.push_back(cyc);
        if (!rxBusy) begin
          if (tx === 1'b0) begin rxBusy = 1'b1; rxCnt = 0; rxStart = cyc; end
        end else begin
          rxCnt = rxCnt + 1;
          if (rxCnt % DIV == DIV/2) begin
            k = rxCnt / DIV;
            if (k == 0) begin
              if (tx !== 1'b0) rxBusy = 1'b0;
            end else if (k <= 8) begin
              rxSh[k-1] = tx;
            end else begin
              chk1("stop bit", tx, 1'b1);
              rxQ.push_back(rxSh);
              rxStartQ.push_back(rxStart);
              rxBusy = 1'b0;
            end
          end
        end
        if (armed) begin
          t = cyc - armT;
          chk1("tx model", tx, expTx(t));
          chk1("dataFrameReset model", dataFrameReset, t == 1);
          chk1("is_transmitting model", is_transmitting, (t >= 2) && (t < 3 + FRAME_CYC));
          chk1("dataNext model", dataNext, expDn(t));
          if (t >= FRAME_CYC + 6) armed = 1'b0;
        end
      end
    end
  end

  initial begin
    int k;
    int riseCyc;
    int holdBad;
    // Reset held with a frame pending: line idle, no strobes.
    rst = 1'b0; frameReady = 1'b1; cts = 1'b1;
    setFrame(16'h1234, 16'hABCD);
    waitCyc(5);
    chk1("reset tx", tx, 1'b1);
    chk1("reset dataNext", dataNext, 1'b0);
    chk1("reset dataFrameReset", dataFrameReset, 1'b0);
    chk1("reset is_transmitting", is_transmitting, 1'b0);
    chkN("model csum 1234/ABCD", 32'(expBytes[NB-1]), 32'h0000_00BE);

    // Release: cts_s needs two cycles, frame decided in the third.
    rst = 1'b1; armT = cyc + 2; armed = 1'b1;
    waitCyc(10); frameReady = 1'b0;
    waitCyc(FRAME_CYC + 10);
    checkFrame("single", armT + 1, 2*BYTE_CYC, FRAME_CYC);
    if (rxQ.size() == NB) begin
      chkN("single lit byte2", 32'(rxQ[2]), 32'h12);
      chkN("single lit byte3", 32'(rxQ[3]), 32'hCD);
      chkN("single lit csum", 32'(rxQ[5]), 32'hBE);
    end

    // Checksum wraps modulo 256.
    setFrame(16'hFFFF, 16'h0102);
    waitCyc(2);
    frameReady = 1'b1; armT = cyc; armed = 1'b1;
    waitCyc(1); frameReady = 1'b0;
    waitCyc(FRAME_CYC + 10);
    chkN("model csum wrap", 32'(expBytes[NB-1]), 32'h01);
    checkFrame("wrap", armT + 1, 2*BYTE_CYC, FRAME_CYC);
    if (rxQ.size() == NB) chkN("wrap lit csum", 32'(rxQ[5]), 32'h01);

    // Flow control: cts drops inside byte 3, rises 50 cycles later.
    setFrame(16'h1357, 16'h2468);
    waitCyc(2);
    frameReady = 1'b1; k = cyc;
    waitCyc(1); frameReady = 1'b0;
    waitCyc(99);
    cts = 1'b0; holdBad = 0;
    for (int i = 0; i < 50; i++) begin
      waitCyc(1);
      if (cyc >= k + 123 && tx !== 1'b1) holdBad = holdBad + 1;
    end
    chkN("tx held while cts low", holdBad, 0);
    chkN("no fetch while cts low", dnQ.size(), 1);
    cts = 1'b1; riseCyc = cyc;
    waitCyc(FRAME_CYC);
    checkFrame("flow", k + 1, (riseCyc + 2) - (k + 2 + BYTE_CYC), FRAME_CYC + (riseCyc + 3) - (k + 3 + 3*BYTE_CYC));
    if (rxStartQ.size() == NB) begin
      chkN("byte3 start unaffected", rxStartQ[2], k + 3 + 2*BYTE_CYC);
      chkN("byte4 start after cts rise", rxStartQ[3] - riseCyc, 3);
    end

    // Asynchronous reset during the high byte of word 0 (all-zero data bits).
    setFrame(16'h0011, 16'h2233);
    waitCyc(2);
    frameReady = 1'b1; k = cyc;
    waitCyc(1); frameReady = 1'b0;
    waitCyc(89);
    chk1("tx low inside HI byte", tx, 1'b0);
    chk1("busy inside HI byte", is_transmitting, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk1("async reset tx", tx, 1'b1);
    chk1("async reset is_transmitting", is_transmitting, 1'b0);
    chk1("async reset dataNext", dataNext, 1'b0);
    setFrame(16'h0011, 16'h2233);
    frameReady = 1'b1;
    waitCyc(3);
    rst = 1'b1; armT = cyc + 2; armed = 1'b1;
    waitCyc(10); frameReady = 1'b0;
    waitCyc(FRAME_CYC + 10);
    checkFrame("restart", armT + 1, 2*BYTE_CYC, FRAME_CYC);
    chkN("model csum restart", 32'(expBytes[NB-1]), 32'h66);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
